alu_op_responder: RTL and testbench

- Responder end of an operation request/response interface. Replaces direct combinational drive of the ALU with a handshaked, sequential execution unit.
- Accepts one request (A, B, select) over a valid/ready handshake and executes it. ADD and SUB take one cycle; MUL (iterative shift-add) and DIV (iterative restoring) take multiple cycles.
- Returns a 16-bit result plus an error flag over a second valid/ready handshake.
- Sits between an op initiator (bench driver or sequencer) and downstream result consumers.

---
 rtl/alu_op_responder.sv | 162 ++++++++++++++++
 tb/tb_alu_op_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_responder.sv
// Handshaked ALU execution unit: ADD/SUB in one cycle, iterative MUL and DIV.
// Optional performance counters (op_cnt, err_cnt) are built when ALU_PERF_CNT_EN is defined.
module alu_op_responder #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [1:0]        req_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OUT_W-1:0]  rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [1:0]        dbg_state
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [15:0]       op_cnt,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] SEL_ADD = 2'd0;
    localparam logic [1:0] SEL_SUB = 2'd1;
    localparam logic [1:0] SEL_MUL = 2'd2;
    localparam logic [1:0] SEL_DIV = 2'd3;

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_MUL = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] LAST_DIV = CNT_W'(DATA_W - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [1:0]        op_sel;
    logic [OUT_W-1:0]  acc;
    logic [DATA_W-1:0] rem;
    logic [OUT_W-1:0]  rsp_data_q;
    logic              rsp_err_q;

    logic [CNT_W-1:0]  last_cnt;
    logic              exec_last;
    logic              b_zero;
    logic [OUT_W-1:0]  acc_nxt;
    logic [DATA_W:0]   rem_sh;
    logic              div_ge;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_nxt;
    logic [OUT_W-1:0]  result;

    // Both handshakes complete on a rising edge where valid && ready are high;
    // the sender holds its payload stable until then, and neither ready waits on valid.
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state;

    always_comb begin
        last_cnt = '0;
        case (op_sel)
            SEL_MUL: last_cnt = LAST_MUL;
            SEL_DIV: last_cnt = LAST_DIV;
            default: last_cnt = '0;
        endcase
        exec_last = (cnt == last_cnt);
        b_zero    = (op_b == '0);

        // MUL: op_a is the shifting multiplicand, op_b the shifting multiplier.
        acc_nxt = op_b[0] ? (acc + op_a[OUT_W-1:0]) : acc;

        // DIV: op_a shifts out dividend bits and shifts in quotient bits.
        rem_sh  = {rem, op_a[DATA_W-1]};
        div_ge  = (rem_sh >= {1'b0, op_b});
        rem_nxt = div_ge ? (rem_sh[DATA_W-1:0] - op_b) : rem_sh[DATA_W-1:0];
        quo_nxt = {op_a[DATA_W-2:0], div_ge};

        result = '0;
        case (op_sel)
            SEL_ADD: result = op_a[OUT_W-1:0] + op_b[OUT_W-1:0];
            SEL_SUB: result = op_a[OUT_W-1:0] - op_b[OUT_W-1:0];
            SEL_MUL: result = acc_nxt;
            default: result = b_zero ? '1 : quo_nxt[OUT_W-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= SEL_ADD;
            acc        <= '0;
            rem        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_a   <= req_a;
                        op_b   <= req_b;
                        op_sel <= req_sel;
                        cnt    <= '0;
                        acc    <= '0;
                        rem    <= '0;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    cnt <= cnt + 1'b1;
                    if (op_sel == SEL_MUL) begin
                        acc  <= acc_nxt;
                        op_a <= op_a << 1;
                        op_b <= op_b >> 1;
                    end else if (op_sel == SEL_DIV) begin
                        rem  <= rem_nxt;
                        op_a <= quo_nxt;
                    end
                    if (exec_last) begin
                        rsp_data_q <= result;
                        rsp_err_q  <= (op_sel == SEL_DIV) && b_zero;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_PERF_CNT_EN
    // op_cnt wraps naturally; err_cnt saturates so a burst of errors stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt  <= '0;
            err_cnt <= '0;
        end else if ((state == ST_RESP) && rsp_ready) begin
            op_cnt <= op_cnt + 1'b1;
            if (rsp_err_q && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_responder.sv
// Scoreboard bench for alu_op_responder: directed cases, backpressure, mid-op reset, random ops.
// Also checks the counters when ALU_PERF_CNT_EN is defined.
module tb_alu_op_responder;

    localparam int DATA_W = 32;
    localparam int OUT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [DATA_W-1:0] req_a = '0;
    logic [DATA_W-1:0] req_b = '0;
    logic [1:0]        req_sel = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [OUT_W-1:0]  rsp_data;
    logic              rsp_err;
    logic              busy;
    logic [1:0]        dbg_state;
`ifdef ALU_PERF_CNT_EN
    logic [15:0]       op_cnt;
    logic [7:0]        err_cnt;
`endif

    alu_op_responder #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .dbg_state (dbg_state)
`ifdef ALU_PERF_CNT_EN
        ,
        .op_cnt    (op_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [OUT_W:0] exp_q[$];   // {err, data}
    int             acc_q[$];   // accept cycle
    int             lat_q[$];   // expected latency
    int n_checks = 0;
    int n_fail   = 0;
    int last_acc_cyc = 0;
    int last_hs_cyc  = 0;
    bit rand_rdy   = 1'b0;
    bit forced_rdy = 1'b1;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on the full operands, then truncation.
    function automatic logic [OUT_W:0] model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] sel);
        logic [63:0] p;
        logic [31:0] r;
        r = '0;
        case (sel)
            2'd0: r = a + b;
            2'd1: r = a - b;
            2'd2: begin p = 64'(a) * 64'(b); r = p[31:0]; end
            default: begin
                if (b == 0) return {1'b1, 16'hFFFF};
                r = a / b;
            end
        endcase
        return {1'b0, r[15:0]};
    endfunction

    function automatic int latency(input logic [1:0] sel);
        case (sel)
            2'd2:    return OUT_W;
            2'd3:    return DATA_W;
            default: return 1;
        endcase
    endfunction

    // ---------------- response-ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : forced_rdy;
        end
    end

    // ---------------- request driver ----------------
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_sel   = sel;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready got 0 expected 1 within 500 cycles");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_acc_cyc = cyc;
        exp_q.push_back(model(a, b, sel));
        acc_q.push_back(cyc);
        lat_q.push_back(latency(sel));
        // Scramble operands after accept; the DUT must ignore them.
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_sel   = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            prev_valid <= rsp_valid;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    if (!prev_valid) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL stale_rsp: got rsp_valid=1 expected 0 (no request pending)");
                    end
                end else begin
                    logic [OUT_W:0] e;
                    e = exp_q[0];
                    if (!prev_valid) check("latency", 32'(cyc - acc_q[0]), 32'(lat_q[0]));
                    if (rsp_ready) begin
                        check("rsp_data", 32'(rsp_data), 32'(e[OUT_W-1:0]));
                        check("rsp_err", 32'(rsp_err), 32'(e[OUT_W]));
                        last_hs_cyc = cyc + 1;
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        void'(lat_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  sel;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operations, consumer always ready.
        forced_rdy = 1'b1;
        issue(32'hFA, 32'h02, 2'd0);
        issue(32'hFA, 32'h02, 2'd1);
        issue(32'hFA, 32'h02, 2'd2);
        issue(32'hFA, 32'h02, 2'd3);
        issue(32'h1234, 32'h0, 2'd3);
        drain();
`ifdef ALU_PERF_CNT_EN
        check("op_cnt", 32'(op_cnt), 32'd5);
        check("err_cnt", 32'(err_cnt), 32'd1);
`endif
        issue(32'h1, 32'h2, 2'd1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2);
        issue(32'hFFFF_FFFF, 32'h1, 2'd3);
        drain();

        // Backpressure: response held, second request must wait for the handshake.
        forced_rdy = 1'b0;
        @(posedge clk);
        #2;
        issue(32'hFFFF_FFFF, 32'h1, 2'd0);
        fork
            issue(32'h3, 32'h4, 2'd0);
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (rsp_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("hold_rsp_seen", 32'(seen), 32'd1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
                    check("hold_rsp_data", 32'(rsp_data), 32'd0);
                    check("hold_req_ready", 32'(req_ready), 32'd0);
                end
                forced_rdy = 1'b1;
            end
        join
        check("accept_after_hs", 32'(last_acc_cyc), 32'(last_hs_cyc + 1));
        drain();

        // Reset in the middle of a DIV: the in-flight request vanishes.
        issue(32'h100, 32'h3, 2'd3);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h5, 32'h7, 2'd0);
        drain();

        // Random operations with random consumer backpressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            sel = 2'($urandom_range(0, 3));
            a   = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1, 2, 3: b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
            issue(a, b, sel);
        end
        drain();
        rand_rdy = 1'b0;
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
